seven_seg_scan: RTL and testbench
=================================

Name: seven_seg_scan

Overview:
Multiplexed N-digit 7-segment driver for the clock display. It captures a packed BCD word through a load strobe and double-buffers it so updates commit only at frame boundaries, which prevents tearing. It time-multiplexes one shared segment bus across N digit enables, with dead time between digits. It sits between the time-keeping counters and the board display pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (2..8)
SCAN_DIV, 1000, clock cycles each digit is selected (>=4)
SEG_ACTIVE_LOW, 0, 1 inverts scan_seg_out and scan_dp_out
DIG_ACTIVE_LOW, 1, 1 inverts scan_dig_out
BLINK_FRAMES, 64, frames per blink half-period (used only with SCAN_BLINK_EN)

Ports:
scan_clk  in  1  system clock
scan_rst_n  in  1  asynchronous active-low reset
scan_bcd_in  in  4*N_DIGITS  packed BCD; digit 0 (rightmost) = bits [3:0]
scan_dp_in  in  N_DIGITS  decimal point per digit
scan_load_in  in  1  single-cycle strobe; captures scan_bcd_in/scan_dp_in into shadow
scan_blink_in  in  N_DIGITS  per-digit blink mask (ignored without SCAN_BLINK_EN)
scan_pending_out  out  1  shadow holds data not yet committed
scan_frame_out  out  1  one-cycle pulse at every frame boundary
scan_seg_out  out  7  segments {a,b,c,d,e,f,g}, a = MSB
scan_dp_out  out  1  decimal point of selected digit
scan_dig_out  out  N_DIGITS  one-hot digit enable

Behaviour:
- Interface: one clock, scan_clk. Reset is asynchronous and active-low on scan_rst_n.
- Reset values: prescaler = 0, digit index = 0. Shadow and active BCD = 4'hF for every digit (blank). DP = 0, pending = 0, frame = 0. All enables inactive, segments inactive, dp inactive (polarity-adjusted).
- Reset mid-frame: immediately returns to the reset state. There is no partial commit.
- Prescaler: counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the index advances (N_DIGITS-1 -> 0 wraps).
- Frame boundary: the edge where the index wraps N_DIGITS-1 -> 0.
  - scan_frame_out is high for the following cycle.
  - If pending = 1, shadow copies to active on that edge and pending clears.
- Load:
  - scan_load_in = 1 writes shadow and sets pending the next cycle.
  - Load while pending overwrites shadow; the last load wins.
  - Load on the same edge as a commit: active takes the OLD shadow, shadow takes the new data, pending stays 1.
- Decode (active-high before polarity; 0-9 only, anything else blanks):
  - 0 -> 1111110, 1 -> 0110000, 2 -> 1101101, 3 -> 1111001, 4 -> 0110011
  - 5 -> 1011011, 6 -> 1011111, 7 -> 1110000, 8 -> 1111111, 9 -> 1111011
  - 10-15 -> 0000000
- Outputs:
  - All outputs are registered, with 1 cycle latency from index/prescaler state.
  - Dead time: while prescaler = 0, all enables are inactive and segments blank.
  - For prescaler >= 1, exactly one enable (bit = index) is active and seg/dp show active[index].
- Width rules: prescaler width = $clog2(SCAN_DIV); index width = $clog2(N_DIGITS), minimum 1 bit.

Optional Feature:
SCAN_BLINK_EN
- Defined:
  - A frame counter toggles a blink phase every BLINK_FRAMES frames; phase resets to 0 (visible).
  - When phase = 1, digits with scan_blink_in[i] = 1 have seg and dp blanked; their enable still follows the scan.
  - scan_blink_in is sampled live, not double-buffered.
- Undefined: no frame counter exists, scan_blink_in is unused, and BLINK_FRAMES has no effect.

Decomposition:
- Package scan_pkg holds:
  - SEG_BLANK constant
  - the 16-entry segment lookup as a typedef'd array constant
  - function bcd_to_seg(logic [3:0]) returning logic [6:0]
- Sub-module scan_digit_decode: combinational; BCD + dp + blank -> 8-bit segment word with polarity applied.
- The top module holds the prescaler, index, shadow/active registers, pending, frame and blink logic.

Test Plan:
1. Reset and blank: N=4, SCAN_DIV=4, rst_n low then high, no load.
   -> enables cycle 1110,1101,1011,0111 (active-low) with one all-1111 dead cycle per slot.
   -> seg = 0000000 throughout; pending = 0.
2. Load 0x1259, dp=0010 mid-frame:
   -> pending = 1 until the next frame boundary, then 0.
   -> digit0 seg 1111011, digit1 1011011 dp=1, digit2 1101101, digit3 0110000.
3. Load and commit on the same edge: load 0x0001, then load 0x0002 timed on the wrap edge.
   -> the frame after shows 0001 with pending still 1.
   -> the following frame shows 0002 with pending 0.
4. Invalid BCD 0xA3F7: digits 1 and 3 blank (seg 0000000), digit 0 shows 1110000, digit 2 shows 1111001.
5. Reset mid-frame: assert rst_n low at index 2, prescaler 3.
   -> outputs go inactive asynchronously.
   -> after release, scanning restarts at digit 0 with the display blank.
6. SCAN_BLINK_EN, BLINK_FRAMES=2, blink=0001, load 0x1234:
   -> digit0 blanked in frames 2-3, 6-7, ...
   -> digits 1-3 unaffected; digit0 enable still pulses.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared segment encoding for the multiplexed 7-segment scanner.
// Segment order is {a,b,c,d,e,f,g} with a in the MSB; all values are active-high.
package scan_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Entry 0 is the leftmost element of the literal.
  typedef logic [0:15][6:0] seg_lut_t;

  localparam seg_lut_t SEG_LUT = {
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011,
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK
  };

  typedef enum logic {
    PH_VISIBLE = 1'b0,
    PH_HIDDEN  = 1'b1
  } blink_phase_e;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    return SEG_LUT[bcd];
  endfunction

endpackage

// File: rtl/scan_digit_decode.sv
// Combinational digit decoder: BCD + dp + blank -> {seg[6:0], dp}.
// Output polarity is applied here.
module scan_digit_decode
  import scan_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic [3:0] bcd_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  logic [7:0] word;

  always_comb begin
    word = {SEG_BLANK, 1'b0};
    if (!blank_i) word = {bcd_to_seg(bcd_i), dp_i};
    seg_o = (SEG_ACTIVE_LOW != 0) ? ~word : word;
  end

endmodule

// File: rtl/seven_seg_scan.sv
// N-digit multiplexed 7-segment driver. Loads go to a shadow buffer that commits at frame boundaries.
// Optional per-digit blinking is enabled by defining SCAN_BLINK_EN.
module seven_seg_scan
  import scan_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int BLINK_FRAMES   = 64
) (
  input  logic                    scan_clk,
  input  logic                    scan_rst_n,
  input  logic [4*N_DIGITS-1:0]   scan_bcd_in,
  input  logic [N_DIGITS-1:0]     scan_dp_in,
  input  logic                    scan_load_in,
  input  logic [N_DIGITS-1:0]     scan_blink_in,
  output logic                    scan_pending_out,
  output logic                    scan_frame_out,
  output logic [6:0]              scan_seg_out,
  output logic                    scan_dp_out,
  output logic [N_DIGITS-1:0]     scan_dig_out
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0]       PSC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                DP_OFF   = (SEG_ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : '0;

  logic [PW-1:0]         psc_q, psc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d, active_q, active_d;
  logic [N_DIGITS-1:0]   shdp_q, shdp_d, actdp_q, actdp_d;
  logic                  pending_q, pending_d;
  logic                  frame_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [N_DIGITS-1:0]   dig_q, dig_d;
  logic                  wrap;
  logic                  blink_hide;
  logic [N_DIGITS-1:0]   onehot;
  logic [3:0]            cur_bcd;
  logic                  cur_dp;
  logic [7:0]            dec_word;

  assign wrap    = (psc_q == PSC_LAST) && (idx_q == IDX_LAST);
  assign onehot  = N_DIGITS'(1) << idx_q;
  assign cur_bcd = active_q[{idx_q, 2'b00} +: 4];
  assign cur_dp  = actdp_q[idx_q];

  // A load on the commit edge still lands in shadow: active takes the old shadow.
  always_comb begin
    psc_d     = psc_q + 1'b1;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    shdp_d    = shdp_q;
    active_d  = active_q;
    actdp_d   = actdp_q;
    pending_d = pending_q;
    dig_d     = DIG_OFF;
    if (psc_q == PSC_LAST) begin
      psc_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (wrap && pending_q) begin
      active_d  = shadow_q;
      actdp_d   = shdp_q;
      pending_d = 1'b0;
    end
    if (scan_load_in) begin
      shadow_d  = scan_bcd_in;
      shdp_d    = scan_dp_in;
      pending_d = 1'b1;
    end
    if (psc_q != '0) dig_d = (DIG_ACTIVE_LOW != 0) ? ~onehot : onehot;
  end

`ifdef SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frm_q, frm_d;
  blink_phase_e  phase_q, phase_d;

  always_comb begin
    frm_d   = frm_q;
    phase_d = phase_q;
    if (wrap) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      frm_q   <= '0;
      phase_q <= PH_VISIBLE;
    end else begin
      frm_q   <= frm_d;
      phase_q <= phase_d;
    end
  end

  assign blink_hide = (phase_q == PH_HIDDEN) && scan_blink_in[idx_q];
`else
  logic unused_blink;
  assign unused_blink = ^scan_blink_in;
  assign blink_hide   = 1'b0;
`endif

  scan_digit_decode #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_decode (
    .bcd_i  (cur_bcd),
    .dp_i   (cur_dp),
    .blank_i((psc_q == '0) || blink_hide),
    .seg_o  (dec_word)
  );

  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      psc_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '1;
      active_q  <= '1;
      shdp_q    <= '0;
      actdp_q   <= '0;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
      seg_q     <= SEG_OFF;
      dp_q      <= DP_OFF;
      dig_q     <= DIG_OFF;
    end else begin
      psc_q     <= psc_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      shdp_q    <= shdp_d;
      actdp_q   <= actdp_d;
      pending_q <= pending_d;
      frame_q   <= wrap;
      seg_q     <= dec_word[7:1];
      dp_q      <= dec_word[0];
      dig_q     <= dig_d;
    end
  end

  assign scan_pending_out = pending_q;
  assign scan_frame_out   = frame_q;
  assign scan_seg_out     = seg_q;
  assign scan_dp_out      = dp_q;
  assign scan_dig_out     = dig_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: N=4, SCAN_DIV=4, active-low enables, active-high segments.
// The blink sequence is compiled in only when SCAN_BLINK_EN is defined.
module tb_seven_seg_scan;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111, S9 = 7'b1111011, SB = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [3:0]  blink = '0;
  logic        pending, frame, dp;
  logic [6:0]  seg;
  logic [3:0]  dig;

  int n_checks = 0;
  int n_fail   = 0;

  seven_seg_scan #(
    .N_DIGITS      (4),
    .SCAN_DIV      (4),
    .SEG_ACTIVE_LOW(0),
    .DIG_ACTIVE_LOW(1),
    .BLINK_FRAMES  (2)
  ) dut (
    .scan_clk        (clk),
    .scan_rst_n      (rst_n),
    .scan_bcd_in     (bcd),
    .scan_dp_in      (dp_in),
    .scan_load_in    (load),
    .scan_blink_in   (blink),
    .scan_pending_out(pending),
    .scan_frame_out  (frame),
    .scan_seg_out    (seg),
    .scan_dp_out     (dp),
    .scan_dig_out    (dig)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic [27:0] segs;  // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d);
    bcd   = b;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = frame;
    end
    check({tag, " frame_seen"}, 16'(seen), 16'd1);
  endtask

  // Checks 16 cycles starting just after a frame pulse (or reset release).
  // Cycle k shows scan slot k-1: slot 0 of each digit is dead time.
  task automatic check_frame(input logic [27:0] segs, input logic [3:0] dps, input string tag);
    for (int k = 1; k <= 16; k++) begin
      logic [12:0] e;
      int d;
      @(negedge clk);
      d = (k - 1) / 4;
      if ((k - 1) % 4 == 0) e = {(k == 16), 4'hF, SB, 1'b0};
      else e = {(k == 16), ~(4'b0001 << d), segs[d*7 +: 7], dps[d]};
      check($sformatf("%s k=%0d {frame,dig,seg,dp}", tag, k),
            {3'b0, frame, dig, seg, dp}, {3'b0, e});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit, expected $finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h1259, 4'b0010, {S1, S2, S5, S9}};
    vecs[1] = '{16'hA3F7, 4'b0000, {SB, S3, SB, S7}};
    vecs[2] = '{16'h8064, 4'b1001, {S8, S0, S6, S4}};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset {frame,dig,seg,dp,pending}", {2'b0, frame, dig, seg, dp, pending},
          {2'b0, 1'b0, 4'hF, SB, 1'b0, 1'b0});
    rst_n = 1'b1;
    check_frame({SB, SB, SB, SB}, 4'h0, "blank");
    check("blank pending", 16'(pending), 16'd0);

    for (int i = 0; i < 3; i++) begin
      do_load(vecs[i].bcd, vecs[i].dp);
      check($sformatf("vec%0d pending_set", i), 16'(pending), 16'd1);
      wait_frame($sformatf("vec%0d", i));
      check($sformatf("vec%0d pending_clr", i), 16'(pending), 16'd0);
      check_frame(vecs[i].segs, vecs[i].dp, $sformatf("vec%0d", i));
    end

    // Load 0001, then load 0002 on the very edge that commits 0001.
    do_load(16'h0001, 4'h0);
    check("same_edge pending_first", 16'(pending), 16'd1);
    repeat (14) @(negedge clk);
    bcd  = 16'h0002;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("same_edge {frame,pending}", {14'b0, frame, pending}, 16'b11);
    check_frame({S0, S0, S0, S1}, 4'h0, "same_edge_old");
    check("same_edge pending_after", 16'(pending), 16'd0);
    check_frame({S0, S0, S0, S2}, 4'h0, "same_edge_new");

    // Reset at index 2, prescaler 3, with an uncommitted load outstanding.
    do_load(16'h9999, 4'hF);
    repeat (10) @(negedge clk);
    check("midreset before dig", 16'(dig), 16'hB);
    rst_n = 1'b0;
    #1;
    check("midreset async {frame,dig,seg,dp,pending}", {2'b0, frame, dig, seg, dp, pending},
          {2'b0, 1'b0, 4'hF, SB, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    check_frame({SB, SB, SB, SB}, 4'h0, "post_reset");
    check("post_reset pending", 16'(pending), 16'd0);

`ifdef SCAN_BLINK_EN
    blink = 4'b0001;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_load(16'h1234, 4'h0);
    wait_frame("blink f0");
    for (int f = 1; f <= 6; f++) begin
      check_frame(((f / 2) % 2 == 1) ? {S1, S2, S3, SB} : {S1, S2, S3, S4}, 4'h0,
                  $sformatf("blink f%0d", f));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
